// File: rtl/swd_pkg.sv
// rtl/swd_pkg.sv - shared acks, FSM states and request/response records for swd_xfer_ctrl
package swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam int RSP_RETRY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_EVAL,
        ST_RESP
    } swd_state_e;

    typedef struct packed {
        logic [1:0]  addr32;
        logic        rnw;
        logic        apndp;
        logic [31:0] wdata;
    } swd_req_t;

    typedef struct packed {
        logic [2:0]             ack;
        logic [31:0]            data;
        logic                   perr;
        logic [RSP_RETRY_W-1:0] retries;
    } swd_rsp_t;

    // Read data and parity are only meaningful for a read that completed OK.
    function automatic swd_rsp_t make_rsp(
        input logic                   rnw,
        input logic [2:0]             ack,
        input logic [31:0]            dread,
        input logic                   perr,
        input logic [RSP_RETRY_W-1:0] retries
    );
        swd_rsp_t r;
        r.ack     = ack;
        r.data    = (rnw && ack == ACK_OK) ? dread : 32'h0;
        r.perr    = (rnw && ack == ACK_OK) ? perr : 1'b0;
        r.retries = retries;
        return r;
    endfunction

endpackage

// File: rtl/swd_xfer_ctrl.sv
// rtl/swd_xfer_ctrl.sv - SWD transfer controller with WAIT retry; SWD_MATCH_EN adds read poll-until-match
module swd_xfer_ctrl
    import swd_pkg::*;
#(
    parameter int RETRY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_addr32,
    input  logic               req_rnw,
    input  logic               req_apndp,
    input  logic [31:0]        req_wdata,
    input  logic [RETRY_W-1:0] wait_retry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_data,
    output logic               rsp_perr,
    output logic [RETRY_W-1:0] rsp_retries,
`ifdef SWD_MATCH_EN
    input  logic               req_match,
    input  logic [31:0]        match_mask,
    input  logic [31:0]        match_value,
    input  logic [RETRY_W-1:0] match_retry,
    output logic               rsp_mismatch,
`endif
    output logic               go,
    input  logic               idle,
    output logic [1:0]         addr32,
    output logic               rnw,
    output logic               apndp,
    output logic [31:0]        dwrite,
    input  logic [2:0]         ack,
    input  logic [31:0]        dread,
    input  logic               perr
);

    swd_state_e         r_state;
    swd_state_e         w_state_nxt;
    swd_req_t           r_req;
    swd_rsp_t           r_rsp;
    logic               r_rsp_valid;
    logic               r_go;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic               w_accept;
    logic               w_wait_retry;
    logic               w_match_retry;
    logic               w_relaunch;

    assign req_ready    = !rst && (r_state == ST_IDLE) && idle;
    assign w_accept     = req_valid && req_ready;
    assign w_wait_retry = (ack == ACK_WAIT) && (r_retry_cnt < wait_retry);

`ifdef SWD_MATCH_EN
    logic               r_match;
    logic [RETRY_W-1:0] r_match_cnt;
    logic               r_rsp_mismatch;
    logic               w_mismatch;

    assign w_mismatch    = r_match && r_req.rnw && (ack == ACK_OK) &&
                           ((dread & match_mask) != match_value);
    assign w_match_retry = w_mismatch && (r_match_cnt < match_retry);
    assign rsp_mismatch  = r_rsp_mismatch;
`else
    assign w_match_retry = 1'b0;
`endif

    assign w_relaunch = w_wait_retry || w_match_retry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)  w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: if (!idle)     w_state_nxt = ST_RUN;
            ST_RUN:    if (idle)      w_state_nxt = ST_EVAL;
            ST_EVAL:   w_state_nxt = w_relaunch ? ST_LAUNCH : ST_RESP;
            ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // go is a registered decode of the next state, so it falls on the edge that sees idle low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_go        <= 1'b0;
            r_req       <= '0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_retry_cnt <= '0;
`ifdef SWD_MATCH_EN
            r_match        <= 1'b0;
            r_match_cnt    <= '0;
            r_rsp_mismatch <= 1'b0;
`endif
        end else begin
            r_go <= (w_state_nxt == ST_LAUNCH);
            if (w_accept) begin
                r_req <= '{addr32: req_addr32, rnw: req_rnw,
                           apndp: req_apndp, wdata: req_wdata};
                r_retry_cnt <= '0;
`ifdef SWD_MATCH_EN
                r_match     <= req_match;
                r_match_cnt <= '0;
`endif
            end
            if (r_state == ST_EVAL) begin
                if (w_wait_retry) begin
                    r_retry_cnt <= (&r_retry_cnt) ? r_retry_cnt : r_retry_cnt + RETRY_W'(1);
                end
`ifdef SWD_MATCH_EN
                else if (w_match_retry) begin
                    r_match_cnt <= (&r_match_cnt) ? r_match_cnt : r_match_cnt + RETRY_W'(1);
                    r_retry_cnt <= '0;
                end
`endif
                else begin
                    r_rsp       <= make_rsp(r_req.rnw, ack, dread, perr,
                                            RSP_RETRY_W'(r_retry_cnt));
                    r_rsp_valid <= 1'b1;
`ifdef SWD_MATCH_EN
                    r_rsp_mismatch <= w_mismatch;
`endif
                end
            end
            if (r_state == ST_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign go          = r_go;
    assign addr32      = r_req.addr32;
    assign rnw         = r_req.rnw;
    assign apndp       = r_req.apndp;
    assign dwrite      = r_req.wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_ack     = r_rsp.ack;
    assign rsp_data    = r_rsp.data;
    assign rsp_perr    = r_rsp.perr;
    assign rsp_retries = RETRY_W'(r_rsp.retries);

endmodule

// File: tb/tb_swd_xfer_ctrl.sv
// tb/tb_swd_xfer_ctrl.sv - self-checking bench for swd_xfer_ctrl with a behavioural pin engine
module tb_swd_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_addr32;
    logic        req_rnw;
    logic        req_apndp;
    logic [31:0] req_wdata;
    logic [15:0] wait_retry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_data;
    logic        rsp_perr;
    logic [15:0] rsp_retries;
    logic        go;
    logic        idle;
    logic [1:0]  addr32;
    logic        rnw;
    logic        apndp;
    logic [31:0] dwrite;
    logic [2:0]  ack;
    logic [31:0] dread;
    logic        perr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] data;
        logic        perr;
        logic [15:0] retries;
    } exp_t;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] data;
        logic        perr;
    } eng_rsp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    eng_rsp_t    eng_script[$];
    eng_rsp_t    eng_def;
    eng_rsp_t    eng_cur;
    logic [35:0] launch_q[$];
    int          eng_launches = 0;
    int          eng_phase = 0;
    int          eng_cnt = 0;
    int          eng_launch_dly = 2;
    int          eng_run_len = 3;
    logic        go_prev = 1'b0;

    always #5 clk = ~clk;

    swd_xfer_ctrl #(.RETRY_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr32(req_addr32), .req_rnw(req_rnw), .req_apndp(req_apndp),
        .req_wdata(req_wdata), .wait_retry(wait_retry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ack(rsp_ack), .rsp_data(rsp_data), .rsp_perr(rsp_perr),
        .rsp_retries(rsp_retries),
        .go(go), .idle(idle), .addr32(addr32), .rnw(rnw), .apndp(apndp),
        .dwrite(dwrite), .ack(ack), .dread(dread), .perr(perr)
    );

    // Pin engine: starts on a go rising edge, drops idle after a delay, returns ack when idle rises.
    initial begin
        idle  = 1'b1;
        ack   = 3'b000;
        dread = 32'h0;
        perr  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                idle      = 1'b1;
                eng_phase = 0;
                go_prev   = 1'b0;
                continue;
            end
            case (eng_phase)
                0: if (go && !go_prev) begin
                    eng_launches++;
                    launch_q.push_back({addr32, rnw, apndp, dwrite});
                    eng_cnt   = eng_launch_dly;
                    eng_phase = 1;
                end
                1: begin
                    checks++;
                    if (go !== 1'b1) begin
                        errors++;
                        $display("FAIL go_held_in_launch: go=%b want 1", go);
                    end
                    if (eng_cnt == 0) begin
                        idle      = 1'b0;
                        eng_cnt   = eng_run_len;
                        eng_phase = 2;
                    end else begin
                        eng_cnt--;
                    end
                end
                default: begin
                    checks++;
                    if (go !== 1'b0) begin
                        errors++;
                        $display("FAIL go_while_busy: go=%b want 0", go);
                    end
                    if (eng_cnt == 0) begin
                        eng_cur = (eng_script.size() > 0) ? eng_script.pop_front() : eng_def;
                        ack       = eng_cur.ack;
                        dread     = eng_cur.data;
                        perr      = eng_cur.perr;
                        idle      = 1'b1;
                        eng_phase = 0;
                    end else begin
                        eng_cnt--;
                    end
                end
            endcase
            go_prev = go;
        end
    end

    // Scoreboard: every response handshake pops one expected record.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: ack=%0h data=%0h", rsp_ack, rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rsp_ack !== mon_e.ack) begin
                        errors++;
                        $display("FAIL rsp_ack: got %0h want %0h", rsp_ack, mon_e.ack);
                    end
                    checks++;
                    if (rsp_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL rsp_data: got %0h want %0h", rsp_data, mon_e.data);
                    end
                    checks++;
                    if (rsp_perr !== mon_e.perr) begin
                        errors++;
                        $display("FAIL rsp_perr: got %0h want %0h", rsp_perr, mon_e.perr);
                    end
                    checks++;
                    if (rsp_retries !== mon_e.retries) begin
                        errors++;
                        $display("FAIL rsp_retries: got %0d want %0d", rsp_retries, mon_e.retries);
                    end
                end
            end
        end
    end

    task automatic send_req(input logic [1:0] a, input logic r, input logic ap, input logic [31:0] wd);
        int  n = 0;
        bit  acc = 0;
        @(posedge clk);
        #1;
        req_addr32 = a;
        req_rnw    = r;
        req_apndp  = ap;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({go, rsp_valid, req_ready, rsp_perr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: go/rsp_valid/req_ready/perr=%b want 0000",
                     {go, rsp_valid, req_ready, rsp_perr});
        end
        checks++;
        if ({rsp_ack, rsp_data, rsp_retries} !== 51'h0) begin
            errors++;
            $display("FAIL reset_rsp: ack=%0h data=%0h retries=%0h want 0", rsp_ack, rsp_data, rsp_retries);
        end
        checks++;
        if ({addr32, rnw, apndp, dwrite} !== 36'h0) begin
            errors++;
            $display("FAIL reset_req: %0h want 0", {addr32, rnw, apndp, dwrite});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_dp_read();
        int n0 = eng_launches;
        wait_retry = 16'd5;
        eng_def = '{ack: 3'b001, data: 32'h2BA01477, perr: 1'b0};
        exp_q.push_back('{ack: 3'b001, data: 32'h2BA01477, perr: 1'b0, retries: 16'd0});
        send_req(2'd0, 1'b1, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (eng_launches - n0 !== 1) begin
            errors++;
            $display("FAIL dp_read_launches: got %0d want 1", eng_launches - n0);
        end
    endtask

    task automatic test_wait_retry();
        int n0 = eng_launches;
        wait_retry = 16'd5;
        launch_q.delete();
        eng_script.push_back('{ack: 3'b010, data: 32'h0, perr: 1'b0});
        eng_script.push_back('{ack: 3'b010, data: 32'h0, perr: 1'b0});
        eng_script.push_back('{ack: 3'b001, data: 32'h5555AAAA, perr: 1'b1});
        exp_q.push_back('{ack: 3'b001, data: 32'h0, perr: 1'b0, retries: 16'd2});
        send_req(2'd1, 1'b0, 1'b1, 32'hDEADBEEF);
        wait_rsp();
        checks++;
        if (eng_launches - n0 !== 3) begin
            errors++;
            $display("FAIL wait_retry_launches: got %0d want 3", eng_launches - n0);
        end
        foreach (launch_q[i]) begin
            checks++;
            if (launch_q[i] !== {2'd1, 1'b0, 1'b1, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL wait_retry_fields[%0d]: got %0h want %0h", i, launch_q[i],
                         {2'd1, 1'b0, 1'b1, 32'hDEADBEEF});
            end
        end
    endtask

    task automatic test_wait_limit(input logic [15:0] lim);
        int n0 = eng_launches;
        wait_retry = lim;
        eng_def = '{ack: 3'b010, data: 32'h11111111, perr: 1'b1};
        exp_q.push_back('{ack: 3'b010, data: 32'h0, perr: 1'b0, retries: lim});
        send_req(2'd3, 1'b1, 1'b1, 32'h0);
        wait_rsp();
        checks++;
        if (eng_launches - n0 !== int'(lim) + 1) begin
            errors++;
            $display("FAIL wait_limit_launches: got %0d want %0d", eng_launches - n0, int'(lim) + 1);
        end
    endtask

    task automatic test_no_retry_ack(input logic [2:0] a);
        int n0 = eng_launches;
        wait_retry = 16'd5;
        eng_def = '{ack: a, data: 32'hFFFFFFFF, perr: 1'b1};
        exp_q.push_back('{ack: a, data: 32'h0, perr: 1'b0, retries: 16'd0});
        send_req(2'd2, 1'b1, 1'b1, 32'h0);
        wait_rsp();
        checks++;
        if (eng_launches - n0 !== 1) begin
            errors++;
            $display("FAIL no_retry_launches_ack%0h: got %0d want 1", a, eng_launches - n0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d_tab [4] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
        logic        r_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        p_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        wait_retry = 16'd2;
        for (int i = 0; i < 4; i++) begin
            eng_script.push_back('{ack: 3'b001, data: d_tab[i], perr: p_tab[i]});
            exp_q.push_back('{ack: 3'b001, data: r_tab[i] ? d_tab[i] : 32'h0,
                              perr: r_tab[i] ? p_tab[i] : 1'b0, retries: 16'd0});
            send_req(2'(i), r_tab[i], 1'b0, 32'h100 + 32'(i));
        end
        wait_rsp();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int n0;
        eng_run_len = 10;
        eng_def = '{ack: 3'b001, data: 32'h77777777, perr: 1'b0};
        send_req(2'd0, 1'b1, 1'b0, 32'h0);
        while (!(idle === 1'b0 && go === 1'b0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reset_mid_reach_run: idle=%b go=%b want 0 0", idle, go);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({go, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_ctrl: go/rsp_valid=%b want 00", {go, rsp_valid});
        end
        checks++;
        if ({rsp_ack, rsp_data, rsp_perr} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_rsp: ack=%0h data=%0h perr=%b want 0", rsp_ack, rsp_data, rsp_perr);
        end
        rst = 1'b0;
        eng_run_len = 3;
        repeat (2) @(posedge clk);
        n0 = eng_launches;
        eng_def = '{ack: 3'b001, data: 32'h0BADF00D, perr: 1'b0};
        exp_q.push_back('{ack: 3'b001, data: 32'h0BADF00D, perr: 1'b0, retries: 16'd0});
        send_req(2'd1, 1'b1, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (eng_launches - n0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_after_launches: got %0d want 1", eng_launches - n0);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        wait_retry = 16'd0;
        eng_def = '{ack: 3'b001, data: 32'hCAFE0001, perr: 1'b0};
        exp_q.push_back('{ack: 3'b001, data: 32'hCAFE0001, perr: 1'b0, retries: 16'd0});
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send_req(2'd2, 1'b1, 1'b0, 32'h0);
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_addr32 = 2'd3;
        req_rnw    = 1'b0;
        req_apndp  = 1'b1;
        req_wdata  = 32'h12345678;
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_ack, rsp_data, rsp_perr} !== {1'b0, 1'b1, 3'b001, 32'hCAFE0001, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b ack=%0h data=%0h want 0 1 1 cafe0001",
                         i, req_ready, rsp_valid, rsp_ack, rsp_data);
            end
        end
        exp_q.push_back('{ack: 3'b001, data: 32'h0, perr: 1'b0, retries: 16'd0});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release: rsp_valid/req_ready=%b want 01", {rsp_valid, req_ready});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if ({go, req_ready, dwrite} !== {1'b1, 1'b0, 32'h12345678}) begin
            errors++;
            $display("FAIL backpressure_next_accept: go=%b ready=%b dwrite=%0h want 1 0 12345678",
                     go, req_ready, dwrite);
        end
        wait_rsp();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr32 = 2'd0;
        req_rnw    = 1'b0;
        req_apndp  = 1'b0;
        req_wdata  = 32'h0;
        wait_retry = 16'd0;
        rsp_ready  = 1'b1;
        eng_def    = '{ack: 3'b001, data: 32'h0, perr: 1'b0};
        test_reset();
        test_dp_read();
        test_wait_retry();
        test_wait_limit(16'd3);
        test_wait_limit(16'd0);
        test_no_retry_ack(3'b100);
        test_no_retry_ack(3'b111);
        test_back_to_back();
        test_reset_mid();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/swd_xfer_ctrl.md
Name: swd_xfer_ctrl

Overview:
- Command controller directly upstream of the SWD pin engine.
- Accepts single DP/AP transfer requests over valid/ready and launches each one on the pin engine via its go/idle handshake.
- Retries automatically on a WAIT ack, up to a configured limit.
- Returns ack, read data, parity error and retry count over a valid/ready response channel.

Parameters:
- RETRY_W, 16, width of the WAIT-retry limit and retry counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_addr32  in  2  address bits 3:2
- req_rnw  in  1  1=read, 0=write
- req_apndp  in  1  1=AP, 0=DP
- req_wdata  in  32  write data
- wait_retry  in  RETRY_W  max re-issues after WAIT (0 = no retry)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_ack  out  3  final ack (001 OK, 010 WAIT, 100 FAULT, other = protocol error)
- rsp_data  out  32  read data (0 for writes or non-OK)
- rsp_perr  out  1  read parity error
- rsp_retries  out  RETRY_W  WAIT retries consumed
- go  out  1  launch to pin engine
- idle  in  1  pin engine idle
- addr32, rnw, apndp  out  2/1/1  held copies of the request
- dwrite  out  32  held write data
- ack  in  3  engine ack
- dread  in  32  engine read data
- perr  in  1  engine parity error

Behaviour:
- Reset: req_ready=0, rsp_valid=0, go=0, all data outputs 0, counters 0, state ST_IDLE. Reset is shared with the pin engine; reset mid-transfer drops go in the same cycle and discards the transfer. No response is produced.
- States: ST_IDLE, ST_LAUNCH, ST_RUN, ST_EVAL, ST_RESP.
- ST_IDLE:
  - req_ready=1 only here, and only while idle=1.
  - On req_valid&&req_ready: latch addr32/rnw/apndp/dwrite, clear retry counter, go=1, enter ST_LAUNCH.
- ST_LAUNCH:
  - Hold go=1 until idle is sampled 0. The engine only samples go on its rising-edge strobe, so this may take many cycles.
  - Then drop go to 0 the next cycle and enter ST_RUN.
- ST_RUN: wait for idle==1, then enter ST_EVAL. ack, dread and perr are stable once idle is back.
- ST_EVAL (one cycle):
  - If ack==010 and retry counter < wait_retry: increment counter (saturating), go=1, enter ST_LAUNCH. Request fields are unchanged.
  - Otherwise: register rsp_ack=ack; rsp_data=dread if rnw&&ack==001, else 0; rsp_perr=perr if rnw&&ack==001, else 0; rsp_retries=counter. Set rsp_valid=1 and enter ST_RESP.
- ST_RESP: hold all rsp_* stable until rsp_valid&&rsp_ready, then clear rsp_valid and enter ST_IDLE. A new request may be accepted no earlier than the following cycle.
- Latency: at least 1 cycle from idle rising to rsp_valid. A request is never accepted while rsp_valid=1.
- Boundaries:
  - wait_retry=0: a WAIT is returned immediately with rsp_retries=0.
  - wait_retry is sampled in ST_EVAL, so a mid-transfer change takes effect at the next evaluation.
  - FAULT and protocol-error acks are never retried.
- go is never high outside ST_LAUNCH, and never high for a cycle in which idle=0 was sampled in ST_LAUNCH.

Optional Feature:
- Macro SWD_MATCH_EN.
- With it defined, add these ports:
  - req_match in 1
  - match_mask in 32
  - match_value in 32
  - match_retry in RETRY_W
  - rsp_mismatch out 1
- Behaviour with SWD_MATCH_EN, for a read with req_match=1 and final ack 001:
  - If (dread&match_mask)!=match_value and match counter < match_retry: relaunch the same read and increment the match counter.
  - Otherwise respond with rsp_mismatch=1 if still unequal.
  - The match counter is separate from the WAIT counter, and the WAIT counter resets on each match relaunch.
- Without SWD_MATCH_EN: ports are absent and behaviour is exactly as above.

Decomposition:
- Shared package swd_pkg holds:
  - ACK_OK=3'b001, ACK_WAIT=3'b010, ACK_FAULT=3'b100
  - the state enum
  - the request struct (addr32, rnw, apndp, wdata)
  - the response struct (ack, data, perr, retries)
- No sub-module; a single FSM with counters is sufficient.

Test Plan:
- DP read addr32=0, engine model acks 001 with dread=0x2BA01477 -> one go pulse, rsp_ack=001, rsp_data=0x2BA01477, rsp_perr=0, rsp_retries=0.
- AP write 0xDEADBEEF, ack 010 twice then 001, wait_retry=5 -> three launches with identical dwrite, rsp_ack=001, rsp_retries=2.
- Ack 010 always, wait_retry=3 -> exactly 4 launches, rsp_ack=010, rsp_retries=3.
- Read, ack 100 -> one launch, rsp_ack=100, rsp_data=0, no retry.
- rsp_ready held 0 for 20 cycles with req_valid=1 -> req_ready stays 0, rsp_* stable. Release -> next request accepted one cycle later.
- rst asserted while in ST_RUN -> go=0 and rsp_valid=0 next cycle; next request completes normally.
